// File: rtl/memdat_responder.sv
`default_nettype none
// ============================================================================
// Module   : memdat_responder
// Purpose  : Memory-side responder for the CS3 bus. Holds the MAR and a
//            2^ADDR_W x 8 data RAM, services wmar/rmem/wmem strobes with a
//            programmable number of wait states and pulses ready on completion.
// Optional : `define MEMDAT_IO_EN to map MAR==IO_ADDR onto the io_in/io_out port
//            instead of RAM. Without it io_out is tied to 0 and io_in is unused.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous active-low reset
//            bus_in   - datapath bus (MAR source / write data)
//            wmar     - load MAR from bus_in (IDLE only)
//            rmem     - read request, held until ready
//            wmem     - write request, held until ready
//            mem_out  - registered read data
//            ready    - one-cycle completion pulse
//            busy     - transaction in progress
//            err      - sticky protocol error, err_clr clears it
//            io_in    - external input port
//            io_out   - external output latch
// Revision : 1.0 - initial release
// ============================================================================
module memdat_responder #(
    parameter int         ADDR_W      = 8,
    parameter int         WAIT_CYCLES = 0,
    parameter logic [7:0] IO_ADDR     = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_in,
    input  logic       wmar,
    input  logic       rmem,
    input  logic       wmem,
    output logic [7:0] mem_out,
    output logic       ready,
    output logic       busy,
    output logic       err,
    input  logic       err_clr,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int         c_DEPTH = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_mar;
    logic [3:0]        r_cnt;
    logic              r_op_wr;
    logic [7:0]        r_mem_out;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [7:0]        r_ram [c_DEPTH];

    logic              w_req_ok;
    logic              w_req_bad;
    logic              w_wmar_bad;
    logic              w_finish;
    logic              w_is_wr;
    logic              w_is_io;
    logic              w_ram_we;
    logic [7:0]        w_rd_data;

    assign w_req_ok   = (r_state == S_IDLE) && (rmem ^ wmem);
    assign w_req_bad  = (r_state == S_IDLE) && rmem && wmem;
    assign w_wmar_bad = (r_state != S_IDLE) && wmar;

    // The access itself happens on the edge that enters DONE, so mem_out is
    // already valid in the cycle that ready is high.
    assign w_finish   = (w_req_ok && (c_WAIT == 4'd0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // In IDLE the op has not been latched yet, so take it from the strobe.
    assign w_is_wr    = (r_state == S_IDLE) ? wmem : r_op_wr;

`ifdef MEMDAT_IO_EN
    logic [7:0] r_io_out;

    assign w_is_io   = (8'(r_mar) == IO_ADDR);
    assign w_rd_data = w_is_io ? io_in : r_ram[r_mar];
    assign io_out    = r_io_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_io_out <= 8'h00;
        end else if (w_finish && w_is_wr && w_is_io) begin
            r_io_out <= bus_in;
        end
    end
`else
    logic w_unused_io;

    assign w_is_io     = 1'b0;
    assign w_rd_data   = r_ram[r_mar];
    assign io_out      = 8'h00;
    assign w_unused_io = ^{io_in, IO_ADDR};
`endif

    // Gated by reset so a request held during reset cannot commit a write.
    assign w_ram_we = reset && w_finish && w_is_wr && !w_is_io;

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_mar] <= bus_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mar     <= '0;
            r_cnt     <= 4'd0;
            r_op_wr   <= 1'b0;
            r_mem_out <= 8'h00;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ready <= 1'b0;

            // A new error event wins over a simultaneous clear.
            if (w_req_bad || w_wmar_bad) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (wmar && (r_state == S_IDLE)) begin
                r_mar <= bus_in[ADDR_W-1:0];
            end

            if (w_finish) begin
                r_ready <= 1'b1;
                if (!w_is_wr) begin
                    r_mem_out <= w_rd_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req_ok) begin
                        r_op_wr <= wmem;
                        r_cnt   <= c_WAIT;
                        r_busy  <= 1'b1;
                        r_state <= (c_WAIT == 4'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_out = r_mem_out;
    assign ready   = r_ready;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
`default_nettype wire
